// File: rtl/mul_pkg.sv
// Shared types for the 64x64 multiplier issue/capture stage.
// Operand widths, issue FSM states and the buffered operation record.
package mul_pkg;

  localparam int OP_W     = 64;
  localparam int PROD_W   = 128;
  // Tag width stored in each buffered operation; the top's TAG_W defaults to it.
  localparam int OP_TAG_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } issue_state_t;

  typedef struct packed {
    logic [OP_W-1:0]     a;
    logic [OP_W-1:0]     b;
    logic [OP_TAG_W-1:0] tag;
  } op_t;

endpackage

// File: rtl/mul64_issue_ctrl_op_fifo.sv
// Synchronous FIFO of op_t records with full/empty flags and no write bypass.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module op_fifo
  import mul_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  op_t  wdata,
  input  logic pop,
  output op_t  rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  op_t           mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: storage is deliberately not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

endmodule

// File: rtl/mul64_issue_ctrl.sv
// Operand issue and product capture in front of the sequential 64x64 multiplier.
// Optional WAIT-state watchdog enabled by defining MUL_TIMEOUT_EN.
module mul64_issue_ctrl
  import mul_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TAG_W          = OP_TAG_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              mul_start,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic [PROD_W-1:0] mul_p,
  input  logic              mul_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_p,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err,
  output logic              busy
);

  issue_state_t     state, state_nxt;
  op_t              fifo_wdata, fifo_head;
  logic             fifo_full, fifo_empty;
  logic             pop, capture, expire, release_res;
  logic             timeout_hit;
  logic [TAG_W-1:0] tag_q;

  assign fifo_wdata = '{a: in_a, b: in_b, tag: OP_TAG_W'(in_tag)};

  op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    capture     = 1'b0;
    expire      = 1'b0;
    release_res = 1'b0;
    unique case (state)
      IDLE: if (!fifo_empty) begin
        pop       = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (mul_valid) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else if (timeout_hit) begin
          expire    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: if (out_ready) begin
        release_res = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a     <= '0;
      mul_b     <= '0;
      tag_q     <= '0;
      out_p     <= '0;
      out_tag   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (pop) begin
        mul_a <= fifo_head.a;
        mul_b <= fifo_head.b;
        tag_q <= TAG_W'(fifo_head.tag);
      end
      if (capture || expire) begin
        out_p     <= capture ? mul_p : '0;
        out_tag   <= tag_q;
        out_valid <= 1'b1;
      end else if (release_res) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // The limit is hit in the cycle the count would step to TIMEOUT_CYCLES.
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      out_err  <= 1'b0;
    end else begin
      if (state == ISSUE)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      if (capture)     out_err <= 1'b0;
      else if (expire) out_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign out_err     = 1'b0;
`endif

  assign in_ready  = !fifo_full;
  assign mul_start = (state == ISSUE);
  assign busy      = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mul64_issue_ctrl.sv
// Scoreboard bench for mul64_issue_ctrl with a behavioural sequential multiplier.
// The timeout scenario runs only when MUL_TIMEOUT_EN is defined.
module tb_mul64_issue_ctrl;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 255;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  in_a = '0;
  logic [63:0]  in_b = '0;
  logic [3:0]   in_tag = '0;
  logic         mul_start;
  logic [63:0]  mul_a, mul_b;
  logic [127:0] mul_p;
  logic         mul_valid;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_p;
  logic [3:0]   out_tag;
  logic         out_err;
  logic         busy;

  always #5 clk = ~clk;

  mul64_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .mul_valid(mul_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag),
    .out_err(out_err), .busy(busy)
  );

  typedef struct {
    logic [127:0] p;
    logic [3:0]   tag;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  // Behavioural multiplier: fixed latency after mul_start, optionally stalled.
  logic         mdl_valid, running;
  logic [127:0] mdl_p;
  logic [63:0]  cap_a, cap_b;
  int           cnt;
  int           lat = 3;
  logic         stall = 1'b0;
  logic         spur_valid = 1'b0;
  logic [127:0] spur_p = '0;

  assign mul_valid = mdl_valid | spur_valid;
  assign mul_p     = spur_valid ? spur_p : mdl_p;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdl_valid <= 1'b0;
      running   <= 1'b0;
      cnt       <= 0;
      mdl_p     <= '0;
      cap_a     <= '0;
      cap_b     <= '0;
    end else begin
      mdl_valid <= 1'b0;
      if (mul_start) begin
        cap_a   <= mul_a;
        cap_b   <= mul_b;
        cnt     <= lat;
        running <= 1'b1;
      end else if (running && !stall) begin
        if (cnt == 0) begin
          mdl_valid <= 1'b1;
          mdl_p     <= {64'b0, cap_a} * {64'b0, cap_b};
          running   <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  int start_cnt = 0;
  int stab_viol = 0;
  int ov_seen   = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      if (mul_start) start_cnt++;
      if ((running || mdl_valid) && (mul_a !== cap_a || mul_b !== cap_b)) stab_viol++;
      if (out_valid) ov_seen++;
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_result: got p=%h tag=%h err=%b, none expected", out_p, out_tag, out_err);
        end else begin
          e = sb.pop_front();
          if (out_p !== e.p || out_tag !== e.tag || out_err !== e.err)
            $display("FAIL result: got p=%h tag=%h err=%b, want p=%h tag=%h err=%b",
                     out_p, out_tag, out_err, e.p, e.tag, e.err);
          else
            passed++;
        end
      end
    end
  end

  task automatic push_op(input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag,
                         input logic [127:0] p, input logic err);
    int n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      total++;
      $display("FAIL push_timeout: in_ready=%b after %0d cycles, want 1", in_ready, n);
    end else begin
      sb.push_back('{p: p, tag: tag, err: err});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n >= budget) $display("FAIL drain: %0d results pending after %0d cycles, want 0", sb.size(), n);
    else passed++;
  endtask

  task automatic wait_running();
    int n = 0;
    while (!running && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (!running) $display("FAIL issue_timeout: no mul_start within %0d cycles", n);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    total++;
    if ({mul_start, out_valid, out_err, busy} !== 4'b0)
      $display("FAIL reset_ctrl: got start/valid/err/busy=%b, want 0000", {mul_start, out_valid, out_err, busy});
    else passed++;
    total++;
    if (mul_a !== 64'd0 || mul_b !== 64'd0)
      $display("FAIL reset_operands: got a=%h b=%h, want 0", mul_a, mul_b);
    else passed++;
    total++;
    if (out_p !== 128'd0 || out_tag !== 4'd0)
      $display("FAIL reset_result: got p=%h tag=%h, want 0", out_p, out_tag);
    else passed++;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    else passed++;
  endtask

  task automatic test_single();
    int s0 = start_cnt;
    lat       = 2;
    out_ready = 1'b1;
    push_op(64'h3, 64'h5, 4'd2, 128'h0F, 1'b0);
    total++;
    if (mul_start !== 1'b0) $display("FAIL start_early: mul_start=%b one cycle after push, want 0", mul_start);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (mul_start !== 1'b1) $display("FAIL start_latency: mul_start=%b two cycles after push, want 1", mul_start);
    else passed++;
    wait_drain(100);
    total++;
    if (start_cnt - s0 !== 1) $display("FAIL start_count: got %0d pulses, want 1", start_cnt - s0);
    else passed++;
  endtask

  task automatic test_max_operands();
    int v0 = stab_viol;
    lat = 6;
    push_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd9,
            128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1'b0);
    wait_drain(100);
    total++;
    if (stab_viol != v0) $display("FAIL operand_stable: %0d cycles with changed mul_a/mul_b, want 0", stab_viol - v0);
    else passed++;
  endtask

  task automatic test_fill();
    int blocked = 0;
    lat   = 1;
    stall = 1'b1;
    push_op(64'd11, 64'd13, 4'hF, 128'd143, 1'b0);
    wait_running();
    for (int i = 0; i < DEPTH; i++) begin
      logic [63:0] a = 64'(i + 1);
      logic [63:0] b = 64'(100 + i * 37);
      push_op(a, b, 4'(i), {64'b0, a} * {64'b0, b}, 1'b0);
    end
    in_valid = 1'b1;
    in_tag   = 4'(DEPTH);
    for (int i = 0; i < 3; i++) begin
      if (in_ready !== 1'b0) blocked++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++;
    if (blocked != 0) $display("FAIL fill_full: in_ready high in %0d of 3 cycles after %0d accepts, want 0", blocked, DEPTH);
    else passed++;
    stall = 1'b0;
    wait_drain(300);
  endtask

  task automatic test_backpressure();
    int           n = 0;
    int           hold_viol = 0;
    int           s0;
    logic [127:0] p0;
    logic [3:0]   t0;
    lat       = 1;
    out_ready = 1'b0;
    push_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 4'd5,
            {64'b0, 64'h1234_5678_9ABC_DEF0} * {64'b0, 64'h0FED_CBA9_8765_4321}, 1'b0);
    push_op(64'd77, 64'd1000, 4'd6, 128'd77000, 1'b0);
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    p0 = out_p;
    t0 = out_tag;
    s0 = start_cnt;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_p !== p0 || out_tag !== t0) hold_viol++;
    end
    total++;
    if (!out_valid || hold_viol != 0) $display("FAIL bp_hold: %0d cycles with result changed, valid=%b, want held", hold_viol, out_valid);
    else passed++;
    total++;
    if (start_cnt != s0) $display("FAIL bp_no_start: got %0d starts while stalled, want 0", start_cnt - s0);
    else passed++;
    out_ready = 1'b1;
    wait_drain(100);
  endtask

  task automatic test_spurious_valid();
    spur_p     = {$urandom, $urandom, $urandom, $urandom};
    spur_valid = 1'b1;
    @(posedge clk); #1;
    spur_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL spurious_valid: out_valid=%b busy=%b, want 0 0", out_valid, busy);
    else passed++;
  endtask

  task automatic test_reset_mid_wait();
    lat = 50;
    push_op(64'd21, 64'd2, 4'd3, 128'd42, 1'b0);
    wait_running();
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL mid_reset: busy=%b out_valid=%b in_ready=%b, want 0 0 1", busy, out_valid, in_ready);
    else passed++;
    sb.delete();
    ov_seen = 0;
    @(negedge clk) rst = 1'b1;
    repeat (60) begin
      @(posedge clk); #1;
    end
    total++;
    if (ov_seen != 0 || busy !== 1'b0) $display("FAIL stale_result: out_valid seen %0d cycles, busy=%b, want 0 0", ov_seen, busy);
    else passed++;
    lat = 2;
    push_op(64'd7, 64'd9, 4'd1, 128'd63, 1'b0);
    wait_drain(100);
  endtask

`ifdef MUL_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    stall     = 1'b1;
    out_ready = 1'b1;
    push_op(64'd2, 64'd3, 4'd9, 128'd0, 1'b1);
    while (!mul_start && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    n = 0;
    while (!out_valid && n < TIMEOUT + 20) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n != TIMEOUT + 1) $display("FAIL timeout_latency: out_valid after %0d cycles, want %0d", n, TIMEOUT + 1);
    else passed++;
    wait_drain(50);
    stall = 1'b0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_max_operands();
    test_fill();
    test_backpressure();
    test_spurious_valid();
    test_reset_mid_wait();
`ifdef MUL_TIMEOUT_EN
    test_timeout();
`endif
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mul64_issue_ctrl.md
Name: mul64_issue_ctrl

Overview:
- Operand-issue and result-capture stage placed directly upstream of the sequential 64x64 Karatsuba multiplier.
- Accepts tagged operand pairs on a ready/valid interface and buffers them in a small FIFO.
- Issues one single-cycle start pulse per operation and holds A/B stable for the multiplier's whole multi-cycle run.
- Captures the 128-bit product on the multiplier's one-cycle valid pulse and presents it, with its tag, on a ready/valid result interface with backpressure.

Parameters:
- DEPTH, 4, operand FIFO entries; power of two, >= 2.
- TAG_W, 4, width of the user tag carried with each operation.
- TIMEOUT_CYCLES, 255, WAIT-state cycle limit; used only with MUL_TIMEOUT_EN.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO not full.
- in_a  in  64  operand A.
- in_b  in  64  operand B.
- in_tag  in  TAG_W  operation tag.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a  out  64  operand A to the multiplier, registered.
- mul_b  out  64  operand B to the multiplier, registered.
- mul_p  in  128  product from the multiplier.
- mul_valid  in  1  one-cycle product-valid pulse from the multiplier.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_p  out  128  captured product.
- out_tag  out  TAG_W  tag of the captured product.
- out_err  out  1  result aborted by timeout.
- busy  out  1  FSM not IDLE or FIFO not empty.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; FIFO empty.
  - mul_start, mul_a, mul_b, out_valid, out_p, out_tag, out_err and busy all 0.
  - in_ready is 1 once reset is released.
- FIFO:
  - Push on in_valid && in_ready; in_ready = !full.
  - No write bypass: when full, in_ready stays 0 even in a cycle that pops.
  - Pointers carry one extra wrap bit to distinguish full from empty.
- FSM:
  - IDLE: if the FIFO is non-empty, register head {a, b, tag} into mul_a, mul_b and tag_q, pop, go to ISSUE.
  - ISSUE: mul_start=1 for exactly this cycle, clear the wait counter, go to WAIT.
  - WAIT: on mul_valid, register out_p <= mul_p, out_tag <= tag_q, out_err <= 0, out_valid <= 1, go to DONE.
  - DONE: hold out_valid, out_p, out_tag and out_err stable until out_valid && out_ready; on that edge out_valid <= 0, go to IDLE.
- Timing:
  - Earliest next pop is the cycle after leaving DONE, so only one operation is in flight.
  - Latency from FIFO head to mul_start is 2 cycles (IDLE load, then ISSUE).
  - Latency from mul_valid to out_valid is 1 cycle.
- mul_a and mul_b change only in IDLE on a pop; they are held from the pop through the mul_valid cycle.
- mul_valid in any state other than WAIT is ignored.
- Push into an empty FIFO: the entry can be popped the following cycle.
- Simultaneous push and pop when not full: both occur; count is unchanged.
- Reset mid-operation: everything is discarded immediately. Resetting the multiplier (active-high reset, inverted at integration) is the top level's responsibility.
- Width rule: the product is passed through unmodified, 128 bits, no truncation.

Optional Feature:
- Macro: MUL_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT, incrementing each cycle.
  - If the count reaches TIMEOUT_CYCLES without mul_valid: out_p <= 0, out_tag <= tag_q, out_err <= 1, out_valid <= 1, go to DONE.
  - If mul_valid arrives in the same cycle the limit is reached, mul_valid wins.
- Undefined: no counter; WAIT is unbounded; out_err is tied to 0.

Decomposition:
- Package mul_pkg:
  - OP_W=64, PROD_W=128.
  - State enum issue_state_t {IDLE, ISSUE, WAIT, DONE}.
  - Struct op_t {a, b, tag}.
- Sub-module op_fifo: parameterised synchronous FIFO of op_t, with push/pop/full/empty.

Test Plan:
- Single op: A=0x0000000000000003, B=0x0000000000000005, tag=2 -> exactly one mul_start pulse; out_p=0x0F, out_tag=2, out_err=0.
- Max operands: A=B=0xFFFFFFFFFFFFFFFF -> out_p=0xFFFFFFFFFFFFFFFE0000000000000001; mul_a and mul_b stable from start through mul_valid.
- Fill: DEPTH+1 back-to-back pushes with the multiplier stalled -> in_ready=0 after DEPTH accepts; results emerge in order with tags 0..DEPTH-1.
- Backpressure: out_ready=0 for 10 cycles -> out_valid, out_p and out_tag held; no new mul_start until the handshake.
- Reset mid-WAIT: rst=0 -> busy=0, out_valid=0, FIFO empty, and no stale result after rst=1.
- With MUL_TIMEOUT_EN, model never asserts mul_valid -> out_valid rises TIMEOUT_CYCLES+1 cycles after ISSUE with out_err=1, out_p=0.
